// File: rtl/studio2_pkg.sv
// -----------------------------------------------------------------------------
// studio2_pkg
// Shared types and default constants for the Studio II cartridge loader.
//   loader_state_t : loader FSM states (IDLE, LOAD, DRAIN, HOLD)
//   *_DEFAULT      : default parameter values used by the loader and its bus
//   sat_inc16      : 16-bit increment that saturates at 16'hFFFF
// -----------------------------------------------------------------------------
package studio2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } loader_state_t;

    localparam logic [7:0]  BIOS_INDEX_DEFAULT  = 8'h00;
    localparam logic [7:0]  CART_INDEX_DEFAULT  = 8'h01;
    localparam int          ADDR_W_DEFAULT      = 12;
    localparam logic [11:0] CART_BASE_DEFAULT   = 12'h400;
    localparam int          REGION_SIZE_DEFAULT = 1024;
    localparam int          RESET_HOLD_DEFAULT  = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/studio2_cart_loader_if.sv
// -----------------------------------------------------------------------------
// studio2_cart_loader_if
// Groups the HPS ioctl download stream and the BIOS/cartridge RAM write port.
//   ioctl_download/index/wr/addr/dout : host -> loader byte stream
//   ioctl_wait                        : loader -> host stall request
//   mem_we/addr/data                  : loader -> RAM write request
//   mem_ready                         : RAM -> loader write accept
// Modports:
//   master : host/RAM side (drives the stream and mem_ready)
//   slave  : the loader
// -----------------------------------------------------------------------------
interface studio2_cart_loader_if #(
    parameter int ADDR_W = studio2_pkg::ADDR_W_DEFAULT
) ();

    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_ready;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
        input  ioctl_wait, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
        output ioctl_wait, mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/studio2_wr_skid.sv
// -----------------------------------------------------------------------------
// studio2_wr_skid
// One-entry address/data buffer between the ioctl stream and the RAM port.
// A push in the same cycle as a pop reloads the entry without a bubble.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : load push_addr/push_data (caller only pushes when push_ready)
//   push_ready  : entry empty, or being emptied this cycle
//   pop_ready   : downstream accepts the held entry this cycle
//   valid       : entry holds a byte (drives the RAM write strobe)
//   addr, data  : held entry
// -----------------------------------------------------------------------------
module studio2_wr_skid #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [7:0]        push_data,
    input  logic              pop_ready,
    output logic              push_ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    assign push_ready = ~valid | pop_ready;

    // NOTE: sequential state is written with <= only, so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the addr/data holding registers are reset too, because they
            // drive the RAM port directly and must read as zero out of reset.
            valid <= 1'b0;
            addr  <= '0;
            data  <= 8'h00;
        end else if (push) begin
            valid <= 1'b1;
            addr  <= push_addr;
            data  <= push_data;
        end else if (valid && pop_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/studio2_cart_loader.sv
// -----------------------------------------------------------------------------
// studio2_cart_loader
// Converts the HPS ioctl download stream into byte writes on the Studio II
// BIOS/cartridge RAM, stalls the host while RAM is busy, and holds the core in
// reset through the download plus RESET_HOLD cycles.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : studio2_cart_loader_if.slave (ioctl stream + RAM write port)
//   core_reset  : reset to CPU/video core (high after reset, during load, during hold)
//   load_done   : one-cycle pulse when the post-download hold expires
//   byte_count  : bytes written this download, saturating at 16'hFFFF
//   overflow    : sticky flag, a byte was dropped; cleared at download start
//   checksum    : mod-256 sum of written bytes
// Build option:
//   STUDIO2_LOADER_CHECKSUM_EN : when defined the checksum accumulator is built;
//                                otherwise checksum is tied to 8'h00.
// -----------------------------------------------------------------------------
module studio2_cart_loader
    import studio2_pkg::*;
#(
    parameter logic [7:0]        BIOS_INDEX  = BIOS_INDEX_DEFAULT,
    parameter logic [7:0]        CART_INDEX  = CART_INDEX_DEFAULT,
    parameter int                ADDR_W      = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] CART_BASE   = CART_BASE_DEFAULT,
    parameter int                REGION_SIZE = REGION_SIZE_DEFAULT,
    parameter int                RESET_HOLD  = RESET_HOLD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    studio2_cart_loader_if.slave  bus,
    output logic                  core_reset,
    output logic                  load_done,
    output logic [15:0]           byte_count,
    output logic                  overflow,
    output logic [7:0]            checksum
);

    localparam int              CNT_W     = $clog2(RESET_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);

    loader_state_t     state;
    logic              dl_q;
    logic              boot_hold;
    logic [CNT_W-1:0]  hold_cnt;

    logic              dl_rise;
    logic              push;
    logic              drop;
    logic [ADDR_W-1:0] push_addr;
    logic              push_ready;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              drain;

    assign dl_rise = bus.ioctl_download & ~dl_q;
    assign drain   = buf_valid & bus.mem_ready;

    // Byte routing: a strobe in LOAD is either pushed into the buffer or
    // dropped (bad index, out-of-region address, or buffer still occupied).
    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        logic index_ok;
        logic addr_ok;
        logic strobe;
        push      = 1'b0;
        drop      = 1'b0;
        push_addr = '0;
        index_ok  = (bus.ioctl_index == BIOS_INDEX) || (bus.ioctl_index == CART_INDEX);
        addr_ok   = bus.ioctl_addr < 25'(REGION_SIZE);
        strobe    = (state == LOAD) && bus.ioctl_wr;
        if (strobe) begin
            if (index_ok && addr_ok && push_ready) begin
                push      = 1'b1;
                push_addr = ((bus.ioctl_index == CART_INDEX) ? CART_BASE : '0)
                            + bus.ioctl_addr[ADDR_W-1:0];
            end else begin
                drop = 1'b1;
            end
        end
    end

    studio2_wr_skid #(.ADDR_W(ADDR_W)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_addr  (push_addr),
        .push_data  (bus.ioctl_dout),
        .pop_ready  (bus.mem_ready),
        .push_ready (push_ready),
        .valid      (buf_valid),
        .addr       (buf_addr),
        .data       (buf_data)
    );

    assign bus.mem_we     = buf_valid;
    assign bus.mem_addr   = buf_addr;
    assign bus.mem_data   = buf_data;
    assign bus.ioctl_wait = buf_valid & ~bus.mem_ready;

    // Sequencing FSM. core_reset is raised on entry to LOAD and only dropped
    // on the transition back to IDLE, so it stays high through LOAD/DRAIN/HOLD.
    // boot_hold reuses the hold counter to keep the core in reset for
    // RESET_HOLD cycles after reset release, without a load_done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            boot_hold  <= 1'b1;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            byte_count <= 16'h0000;
            overflow   <= 1'b0;
        end else begin
            dl_q      <= bus.ioctl_download;
            load_done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (dl_rise) begin
                        state      <= LOAD;
                        core_reset <= 1'b1;
                        boot_hold  <= 1'b0;
                        hold_cnt   <= '0;
                    end else if (boot_hold) begin
                        if (hold_cnt == HOLD_LAST) begin
                            boot_hold  <= 1'b0;
                            core_reset <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (!bus.ioctl_download) state <= DRAIN;
                end
                DRAIN: begin
                    if (dl_rise) begin
                        state <= LOAD;
                    end else if (!buf_valid) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (dl_rise) begin
                        state <= LOAD;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= IDLE;
                        core_reset <= 1'b0;
                        load_done  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new download wins over any write still landing this cycle.
            if (dl_rise) begin
                byte_count <= 16'h0000;
                overflow   <= 1'b0;
            end else begin
                if (drain) byte_count <= sat_inc16(byte_count);
                if (drop)  overflow   <= 1'b1;
            end
        end
    end

`ifdef STUDIO2_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (dl_rise) begin
            sum_q <= 8'h00;
        end else if (drain) begin
            sum_q <= sum_q + buf_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_studio2_cart_loader.sv
// -----------------------------------------------------------------------------
// tb_studio2_cart_loader
// Self-checking bench for studio2_cart_loader. A reference model holds the
// queue of RAM writes the host stream should produce plus the expected
// byte count, checksum and overflow; a negedge monitor compares every RAM
// write against the queue. Inputs change 2-3 time units after posedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_studio2_cart_loader;
    import studio2_pkg::*;

    localparam int          RESET_HOLD  = 16;
    localparam int          REGION_SIZE = 1024;
    localparam logic [11:0] CART_BASE   = 12'h400;
    localparam logic [7:0]  BIOS_IDX    = 8'h00;
    localparam logic [7:0]  CART_IDX    = 8'h01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_reset;
    logic        load_done;
    logic [15:0] byte_count;
    logic        overflow;
    logic [7:0]  checksum;

    studio2_cart_loader_if bus_if ();

    studio2_cart_loader #(.RESET_HOLD(RESET_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .core_reset (core_reset),
        .load_done  (load_done),
        .byte_count (byte_count),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_w;
    int         exp_count;
    logic [7:0] exp_sum;
    logic       exp_ovf;
    int         done_pulses = 0;
    int         ready_mode  = 1;   // 0 random, 1 always ready, 2 never ready
    int         ready_lo    = 0;   // forced not-ready cycles, overrides mode

    function automatic logic [7:0] exp_cs();
`ifdef STUDIO2_LOADER_CHECKSUM_EN
        return exp_sum;
`else
        return 8'h00;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (load_done) done_pulses++;
            if (bus_if.mem_we && bus_if.mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'(bus_if.mem_we), 32'd0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("wr_addr", 32'(bus_if.mem_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(bus_if.mem_data), 32'(mon_w.data));
                end
            end
        end
    end

    // One clock: advance, drive mem_ready, then check the host stall flag.
    // A byte is in the buffer exactly when the model still has it queued.
    task automatic tick();
        @(posedge clk);
        #2;
        if (ready_lo > 0) begin
            bus_if.mem_ready = 1'b0;
            ready_lo--;
        end else begin
            case (ready_mode)
                0:       bus_if.mem_ready = ($urandom_range(0, 3) != 0);
                1:       bus_if.mem_ready = 1'b1;
                default: bus_if.mem_ready = 1'b0;
            endcase
        end
        #1;
        if (!reset)
            check("ioctl_wait", 32'(bus_if.ioctl_wait),
                  32'((exp_q.size() != 0) && !bus_if.mem_ready));
    endtask

    task automatic send_byte(input logic [7:0] idx, input int addr, input logic [7:0] data,
                             output int stalls);
        bit  ok;
        wr_t w;
        stalls = 0;
        while (bus_if.ioctl_wait && stalls < 200) begin
            tick();
            stalls++;
        end
        if (stalls >= 200) check("wait_timeout", 32'(stalls), 32'd0);
        bus_if.ioctl_index = idx;
        bus_if.ioctl_addr  = 25'(addr);
        bus_if.ioctl_dout  = data;
        bus_if.ioctl_wr    = 1'b1;
        ok = ((idx == BIOS_IDX) || (idx == CART_IDX)) && (addr < REGION_SIZE);
        if (ok) begin
            w.addr = ((idx == CART_IDX) ? CART_BASE : 12'h000) + 12'(addr);
            w.data = data;
            exp_q.push_back(w);
            if (exp_count < 65535) exp_count++;
            exp_sum = exp_sum + data;
        end else begin
            exp_ovf = 1'b1;
        end
        tick();
        bus_if.ioctl_wr = 1'b0;
    endtask

    task automatic start_download();
        bus_if.ioctl_download = 1'b1;
        exp_count = 0;
        exp_sum   = 8'h00;
        exp_ovf   = 1'b0;
        tick();
        check("start_count", 32'(byte_count), 32'd0);
        check("start_ovf", 32'(overflow), 32'd0);
        check("start_cs", 32'(checksum), 32'd0);
        check("start_core_reset", 32'(core_reset), 32'd1);
    endtask

    // Ends the download once the model queue is empty; the DUT then needs one
    // edge for LOAD->DRAIN, one for DRAIN->HOLD, and RESET_HOLD cycles of HOLD.
    task automatic end_download();
        int n;
        int d0;
        bit cr_held;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_budget", 32'(exp_q.size()), 32'd0);
        bus_if.ioctl_download = 1'b0;
        d0 = done_pulses;
        cr_held = 1'b1;
        n = 0;
        while (!load_done && n < 200) begin
            if (!core_reset) cr_held = 1'b0;
            tick();
            n++;
        end
        check("done_latency", 32'(n), 32'(RESET_HOLD + 2));
        check("core_reset_held", 32'(cr_held), 32'd1);
        check("core_reset_release", 32'(core_reset), 32'd0);
        check("byte_count", 32'(byte_count), 32'(exp_count));
        check("checksum", 32'(checksum), 32'(exp_cs()));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        tick();
        check("done_pulse_width", 32'(load_done), 32'd0);
        check("done_pulse_count", 32'(done_pulses - d0), 32'd1);
    endtask

    task automatic boot_release();
        int n;
        int d0;
        d0 = done_pulses;
        reset = 1'b0;
        n = 0;
        while (core_reset && n < 100) begin
            tick();
            n++;
        end
        check("boot_hold_cycles", 32'(n), 32'(RESET_HOLD));
        repeat (3) tick();
        check("boot_no_done", 32'(done_pulses - d0), 32'd0);
        check("boot_core_reset_low", 32'(core_reset), 32'd0);
    endtask

    int st;
    int st_sum;
    logic [7:0] cart_bytes [4];

    initial begin
        bus_if.ioctl_download = 1'b0;
        bus_if.ioctl_index    = 8'h00;
        bus_if.ioctl_wr       = 1'b0;
        bus_if.ioctl_addr     = '0;
        bus_if.ioctl_dout     = 8'h00;
        bus_if.mem_ready      = 1'b1;
        exp_count = 0;
        exp_sum   = 8'h00;
        exp_ovf   = 1'b0;

        // Reset values, then the power-on core_reset hold.
        repeat (3) tick();
        check("rst_wait", 32'(bus_if.ioctl_wait), 32'd0);
        check("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        check("rst_mem_data", 32'(bus_if.mem_data), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        boot_release();

        // CART download of 11,22,33,44 with RAM always ready: no stalls.
        ready_mode = 1;
        cart_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_download();
        st_sum = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(CART_IDX, i, cart_bytes[i], st);
            st_sum += st;
        end
        check("full_rate_stalls", 32'(st_sum), 32'd0);
        end_download();

        // RAM busy for 5 cycles while byte 2 is buffered.
        start_download();
        send_byte(CART_IDX, 16, 8'h5A, st);
        ready_lo = 5;
        send_byte(CART_IDX, 17, 8'hA5, st);
        send_byte(CART_IDX, 18, 8'h3C, st);
        check("stall_cycles", 32'(st), 32'd5);
        end_download();

        // Out-of-region address and unknown index are dropped.
        start_download();
        send_byte(BIOS_IDX, 3, 8'h77, st);
        send_byte(BIOS_IDX, REGION_SIZE, 8'h99, st);
        send_byte(8'h05, 2, 8'h66, st);
        repeat (2) tick();
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_count", 32'(byte_count), 32'd1);
        end_download();

        // Strobe while the buffer is full: dropped and flagged.
        start_download();
        ready_mode = 2;
        send_byte(BIOS_IDX, 5, 8'h42, st);
        check("violation_wait", 32'(bus_if.ioctl_wait), 32'd1);
        bus_if.ioctl_index = BIOS_IDX;
        bus_if.ioctl_addr  = 25'd6;
        bus_if.ioctl_dout  = 8'hEE;
        bus_if.ioctl_wr    = 1'b1;
        exp_ovf = 1'b1;
        tick();
        bus_if.ioctl_wr = 1'b0;
        check("violation_ovf", 32'(overflow), 32'd1);
        ready_mode = 1;
        end_download();

        // New download starts while the previous one is in HOLD.
        start_download();
        send_byte(CART_IDX, 0, 8'h01, st);
        send_byte(CART_IDX, 1, 8'h02, st);
        tick();
        bus_if.ioctl_download = 1'b0;
        st = done_pulses;
        repeat (5) tick();
        check("hold_core_reset", 32'(core_reset), 32'd1);
        start_download();
        check("restart_no_done", 32'(done_pulses), 32'(st));
        send_byte(CART_IDX, 8, 8'h10, st);
        send_byte(BIOS_IDX, 9, 8'h20, st);
        send_byte(CART_IDX, 10, 8'h30, st);
        end_download();

        // Randomized downloads with random RAM back-pressure.
        ready_mode = 0;
        for (int d = 0; d < 6; d++) begin
            int nb;
            start_download();
            nb = $urandom_range(3, 12);
            for (int b = 0; b < nb; b++) begin
                int r;
                int a;
                logic [7:0] idx;
                r   = $urandom_range(0, 9);
                idx = (r < 4) ? BIOS_IDX : ((r < 9) ? CART_IDX : 8'h05);
                a   = ($urandom_range(0, 9) == 0) ? $urandom_range(REGION_SIZE, REGION_SIZE + 80)
                                                  : $urandom_range(0, REGION_SIZE - 1);
                send_byte(idx, a, 8'($urandom), st);
                repeat ($urandom_range(0, 2)) tick();
            end
            end_download();
        end
        ready_mode = 1;

        // Asynchronous reset mid-LOAD with a byte stuck in the buffer.
        start_download();
        ready_mode = 2;
        send_byte(CART_IDX, 7, 8'hC3, st);
        check("pre_reset_we", 32'(bus_if.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("async_mem_we", 32'(bus_if.mem_we), 32'd0);
        check("async_wait", 32'(bus_if.ioctl_wait), 32'd0);
        check("async_core_reset", 32'(core_reset), 32'd1);
        exp_q.delete();
        bus_if.ioctl_download = 1'b0;
        ready_mode = 1;
        repeat (3) tick();
        boot_release();
        check("post_reset_count", 32'(byte_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
